// File: rtl/maze_tile_arbiter.sv
// Round-robin tile-memory arbiter: one grant per cycle, response exactly MEM_LAT cycles after gnt.
// No backpressure on responses; freeze stalls new grants while in-flight queries drain.
module maze_tile_arbiter #(
   parameter int NREQ    = 5,
   parameter int MEM_LAT = 1,
   parameter int XTILES  = 28
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*12-1:0]   req_tile,
   input  logic                 freeze,
   output logic [NREQ-1:0]      gnt,
   output logic                 mem_en,
   output logic [11:0]          mem_addr,
   input  logic [1:0]           mem_rdata,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [1:0]           rsp_info,
   output logic                 busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] r_gnt;
   logic            r_mem_en;
   logic [11:0]     r_mem_addr;
   logic            r_forced;
   logic [NREQ-1:0] r_pv [MEM_LAT];
   logic            r_pf [MEM_LAT];

   logic [NREQ-1:0] w_cand;
   logic            w_found;
   logic [PW-1:0]   w_win;
   logic [PW-1:0]   w_next;
   logic [11:0]     w_tile;
   logic            w_offmaze;
   logic            w_grant;
   logic            w_busy;

   // The requester holding gnt this cycle sits out, so a level req is never granted twice in a row.
   assign w_cand = req & ~r_gnt;

   always_comb begin
      int idx;
      w_found = 1'b0;
      w_win   = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!w_found && w_cand[idx]) begin
            w_found = 1'b1;
            w_win   = PW'(idx);
         end
      end
   end

   assign w_next    = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;
   assign w_tile    = req_tile[int'(w_win)*12 +: 12];
   assign w_offmaze = int'(w_tile[11:6]) >= XTILES;
   assign w_grant   = w_found && !freeze;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_mem_en   <= 1'b0;
         r_mem_addr <= '0;
         r_forced   <= 1'b0;
         for (int s = 0; s < MEM_LAT; s++) begin
            r_pv[s] <= '0;
            r_pf[s] <= 1'b0;
         end
      end else begin
         r_gnt    <= '0;
         r_mem_en <= 1'b0;
         r_forced <= 1'b0;
         if (w_grant) begin
            r_gnt    <= NREQ'(1) << w_win;
            r_ptr    <= w_next;
            r_forced <= w_offmaze;
            // Tunnel tiles never touch memory; mem_addr keeps its previous value.
            if (!w_offmaze) begin
               r_mem_en   <= 1'b1;
               r_mem_addr <= w_tile;
            end
         end
         r_pv[0] <= r_gnt;
         r_pf[0] <= r_forced;
         for (int s = 1; s < MEM_LAT; s++) begin
            r_pv[s] <= r_pv[s-1];
            r_pf[s] <= r_pf[s-1];
         end
      end
   end

   always_comb begin
      w_busy = |r_gnt;
      for (int s = 0; s < MEM_LAT; s++) w_busy = w_busy | (|r_pv[s]);
   end

   assign gnt       = r_gnt;
   assign mem_en    = r_mem_en;
   assign mem_addr  = r_mem_addr;
   assign rsp_valid = r_pv[MEM_LAT-1];
   assign rsp_info  = (|r_pv[MEM_LAT-1] && !r_pf[MEM_LAT-1]) ? mem_rdata : 2'b00;
   assign busy      = w_busy;

endmodule

// File: tb/tb_maze_tile_arbiter.sv
// Randomized scoreboard bench for maze_tile_arbiter with a delayed tile-memory model.
module tb_maze_tile_arbiter;

   localparam int NREQ = 5;
   localparam int LAT  = 2;
   localparam int XT   = 28;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*12-1:0]  req_tile = '0;
   logic                freeze = 1'b0;
   logic [NREQ-1:0]     gnt;
   logic                mem_en;
   logic [11:0]         mem_addr;
   logic [1:0]          mem_rdata;
   logic [NREQ-1:0]     rsp_valid;
   logic [1:0]          rsp_info;
   logic                busy;

   maze_tile_arbiter #(.NREQ(NREQ), .MEM_LAT(LAT), .XTILES(XT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_tile(req_tile), .freeze(freeze),
      .gnt(gnt), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_info(rsp_info), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] info_of(input logic [11:0] a);
      return a[1:0] ^ a[7:6];
   endfunction

   // Tile memory: data for a strobed address appears LAT cycles later, garbage otherwise.
   logic [12:0] mq [LAT];
   always @(posedge clk) begin
      mq[0] <= {mem_en, mem_addr};
      for (int i = 1; i < LAT; i++) mq[i] <= mq[i-1];
   end
   assign mem_rdata = mq[LAT-1][12] ? info_of(mq[LAT-1][11:0]) : 2'b11;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int         id;
      logic [1:0] info;
      int         due;
   } exp_t;
   exp_t sb[$];

   // Reference model: expected outputs for the current cycle, plus list of grant cycles.
   int              m_ptr = 0;
   int              m_cur = -1;
   logic [NREQ-1:0] m_gnt = '0;
   logic            m_en = 1'b0;
   logic [11:0]     m_addr = '0;
   int              m_gcyc[$];

   always @(negedge clk) begin
      logic            eb;
      int              win;
      logic [11:0]     tile;
      logic            off;
      eb = 1'b0;
      foreach (m_gcyc[i]) if (m_gcyc[i] >= cyc - LAT && m_gcyc[i] <= cyc) eb = 1'b1;
      if (!rst) begin
         chk("gnt_rst", gnt, 0);
         chk("mem_en_rst", mem_en, 0);
         chk("mem_addr_rst", mem_addr, 0);
         chk("busy_rst", busy, 0);
         m_ptr = 0; m_cur = -1; m_gnt = '0; m_en = 1'b0; m_addr = '0;
         sb.delete();
         m_gcyc.delete();
      end else begin
         chk("gnt", gnt, m_gnt);
         chk("mem_en", mem_en, m_en);
         chk("mem_addr", mem_addr, m_addr);
         chk("busy", busy, eb);
         win = -1;
         if (!freeze) begin
            for (int k = 0; k < NREQ; k++) begin
               int j;
               j = (m_ptr + k) % NREQ;
               if (win < 0 && req[j] && j != m_cur) win = j;
            end
         end
         if (win >= 0) begin
            tile  = req_tile[win*12 +: 12];
            off   = int'(tile[11:6]) >= XT;
            m_gnt = NREQ'(1) << win;
            m_en  = !off;
            if (!off) m_addr = tile;
            m_ptr = (win + 1) % NREQ;
            m_cur = win;
            sb.push_back('{win, off ? 2'b00 : info_of(tile), cyc + 1 + LAT});
            m_gcyc.push_back(cyc + 1);
         end else begin
            m_gnt = '0;
            m_en  = 1'b0;
            m_cur = -1;
         end
         while (m_gcyc.size() > 0 && m_gcyc[0] < cyc - LAT) void'(m_gcyc.pop_front());
      end
   end

   // Response monitor: any cycle without a due entry must be idle.
   always @(negedge clk) begin
      if (rst && sb.size() > 0 && sb[0].due == cyc) begin
         chk("rsp_valid", rsp_valid, 32'(1) << sb[0].id);
         chk("rsp_info", rsp_info, sb[0].info);
         void'(sb.pop_front());
      end else begin
         chk("rsp_idle_valid", rsp_valid, 0);
         chk("rsp_idle_info", rsp_info, 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int id, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1);
         if (gnt[id]) seen = 1'b1;
      end
      chk(name, seen, 1);
   endtask

   initial begin
      step(3);
      rst = 1'b1;
      req = '1;
      for (int i = 0; i < NREQ; i++)
         req_tile[i*12 +: 12] = {6'($urandom_range(0, XT-1)), 6'($urandom_range(0, 63))};
      step(12);

      req = 5'b00100;
      req_tile[2*12 +: 12] = {6'd5, 6'd10};
      step(10);
      chk("tile_5_10_addr", mem_addr, 12'h14A);

      req = 5'b00001;
      req_tile[0 +: 12] = {6'd28, 6'd17};
      step(6);
      chk("offmaze_addr_hold", mem_addr, 12'h14A);
      req = '0;
      step(LAT + 2);

      req = 5'b11000;
      req_tile[3*12 +: 12] = {6'd3, 6'd4};
      req_tile[4*12 +: 12] = {6'd20, 6'd30};
      wait_gnt(3, "wait_gnt3");
      freeze = 1'b1;
      step(5);
      freeze = 1'b0;
      step(1);
      chk("first_gnt_after_freeze", gnt, 5'b10000);
      step(3);
      req = '0;
      step(LAT + 2);

      req = 5'b00010;
      req_tile[1*12 +: 12] = {6'd7, 6'd9};
      wait_gnt(1, "wait_gnt1");
      step(1);
      rst = 1'b0;
      req = '1;
      step(1);
      rst = 1'b1;
      step(1);
      chk("first_gnt_after_rst", gnt, 5'b00001);

      for (int c = 0; c < 300; c++) begin
         req    = NREQ'($urandom);
         freeze = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < NREQ; i++)
            req_tile[i*12 +: 12] = {6'($urandom_range(0, 35)), 6'($urandom_range(0, 63))};
         rst = (c != 150);
         step(1);
      end
      rst = 1'b1;
      req = '0;
      freeze = 1'b0;
      step(LAT + 4);
      chk("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/maze_tile_arbiter.md
MAZE_TILE_ARBITER -- requirements
Module: maze_tile_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 5, number of requesters: 0=pacman, 1=blinky, 2=pinky, 3=inky, 4=clyde.
REQ-002 SHALL have parameter MEM_LAT, default 1, tile-memory read latency in cycles, legal range 1..3.
REQ-003 SHALL have parameter XTILES, default 28, number of maze columns; columns at or above this value are off-maze.
REQ-004 SHALL have port clk, input, 1 bit: single clock (gameclk domain).
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NREQ bits: per-requester tile-query request, level.
REQ-007 SHALL have port req_tile, input, NREQ*12 bits: requester i tile at [12i+11:12i], as {x[5:0], y[5:0]}.
REQ-008 SHALL have port freeze, input, 1 bit: when high, no new grants are issued (score pause).
REQ-009 SHALL have port gnt, output, NREQ bits: registered one-hot grant pulse.
REQ-010 SHALL have port mem_en, output, 1 bit: tile-memory read strobe.
REQ-011 SHALL have port mem_addr, output, 12 bits: tile-memory address {x, y}.
REQ-012 SHALL have port mem_rdata, input, 2 bits: tile info, valid MEM_LAT cycles after mem_en.
REQ-013 SHALL have port rsp_valid, output, NREQ bits: one-hot response pulse.
REQ-014 SHALL have port rsp_info, output, 2 bits: response data shared by all requesters. Encoding: 00 empty, 01 pellet, 10 power pellet, 11 wall.
REQ-015 SHALL have port busy, output, 1 bit: high while any query is in flight.

Function
REQ-016 Arbitration SHALL be combinational on req, the mask and the round-robin pointer; the winner SHALL be registered onto gnt/mem_addr/mem_en at the next edge.
REQ-017 SHALL issue at most one grant per cycle; gnt SHALL be one-hot or zero and high for exactly one cycle per grant.
REQ-018 Round-robin: search SHALL start at ptr; after granting i, ptr SHALL become (i+1) mod NREQ; ptr SHALL be unchanged when nothing is granted.
REQ-019 The requester whose gnt is currently high SHALL be excluded from the arbitration of that cycle; a requester is expected to drop or refresh req in the cycle after gnt.
REQ-020 Back-to-back grants to different requesters on consecutive cycles SHALL be supported; the same requester SHALL be granted at most every 2nd cycle.
REQ-021 With freeze=1: no new grant, mem_en=0, ptr held; in-flight queries SHALL still complete and respond.
REQ-022 For an in-range tile (x<XTILES), mem_en=1 SHALL coincide with gnt, with mem_addr = the granted req_tile as sampled at the arbitration edge.
REQ-023 For an off-maze tile (x>=XTILES, tunnel), mem_en SHALL stay 0 and the response SHALL be forced to 00 with the same latency.
REQ-024 A requester-ID/valid/forced-flag pipeline of depth MEM_LAT SHALL track each query; rsp_valid[i] and rsp_info SHALL be asserted exactly MEM_LAT cycles after gnt[i].
REQ-025 rsp_info SHALL be mem_rdata passed through unregistered when rsp_valid is high, and 00 when rsp_valid is low.
REQ-026 busy SHALL be the OR of gnt and all pipeline valid stages.
REQ-027 mem_addr SHALL hold its last value when mem_en=0.

Reset
REQ-028 While rst=0: gnt=0, mem_en=0, mem_addr=0, rsp_valid=0, rsp_info=00, busy=0, ptr=0, mask cleared, pipeline invalidated.
REQ-029 A reset asserted mid-query SHALL discard the query; no rsp_valid SHALL occur for it after release.
REQ-030 The first arbitration after release SHALL occur on the first clk edge with rst=1.

Verification
REQ-031 All 5 req high constantly, freeze=0 -> grants 0,1,2,3,4,0,... one per cycle, with each rsp_valid[i] MEM_LAT cycles after gnt[i].
REQ-032 Only req[2] high, tile {5,10} -> gnt[2] on every 2nd cycle, mem_addr=0x14A, rsp_info equals mem_rdata.
REQ-033 req[0] with x=28, y=17 -> mem_en stays 0; rsp_valid[0] with rsp_info=00 after MEM_LAT cycles.
REQ-034 freeze raised the cycle after gnt[3] while req[4] is pending -> rsp_valid[3] still fires, no gnt during freeze, gnt[4] is the first grant after freeze drops.
REQ-035 rst pulsed low one cycle after gnt[1] with MEM_LAT=2 -> rsp_valid[1] never fires, busy=0, next grant starts from ptr=0.
